// File: rtl/ps_bc_pkg.sv
// Shared definitions for the bus-connect arbiter: requester indices, FSM state type
// and the default watchdog hold limit.
package ps_bc_pkg;

    localparam int BC_REQ_STK  = 0;
    localparam int BC_REQ_DM   = 1;
    localparam int BC_REQ_URG  = 2;
    localparam int BC_REQ_HOST = 3;

    localparam int BC_MAXHOLD_DEF = 8;

    typedef enum logic {
        BC_IDLE = 1'b0,
        BC_OWN  = 1'b1
    } bc_state_e;

endpackage

// File: rtl/ps_bc_rr_pick.sv
// Combinational winner selection: requester 0 has fixed priority, the rest are
// scanned round-robin starting at rr_ptr_i (which is always in 1..NREQ-1).
module ps_bc_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
    output logic                    found_o,
    output logic [$clog2(NREQ)-1:0] winner_o
);
    localparam int IW = $clog2(NREQ);

    int idx;

    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        if (req_i[0]) begin
            found_o = 1'b1;
        end else begin
            for (int k = 0; k < NREQ - 1; k++) begin
                // Wrap within 1..NREQ-1 so the stack port is never revisited here.
                idx = int'(rr_ptr_i) + k;
                if (idx > NREQ - 1) idx = idx - (NREQ - 1);
                if (!found_o && req_i[IW'(idx)]) begin
                    found_o  = 1'b1;
                    winner_o = IW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/ps_bc_arbiter.sv
// Bus-connect arbiter: one owner at a time, lock-extended grants bounded by a
// watchdog hold limit, registered one-hot grant and encoded owner.
//
// state    | meaning
// BC_IDLE  | no owner, arbitrate every cycle
// BC_OWN   | grant active; keep while locked and under MAXHOLD, else re-arbitrate
module ps_bc_arbiter
    import ps_bc_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MAXHOLD = BC_MAXHOLD_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         ps_bc_req,
    input  logic [NREQ-1:0]         ps_bc_lock,
    output logic [NREQ-1:0]         ps_bc_gnt,
    output logic [$clog2(NREQ)-1:0] ps_bc_own,
    output logic                    ps_bc_vld,
    output logic                    ps_bc_tmo
);
    localparam int IW = $clog2(NREQ);
    localparam int HW = $clog2(MAXHOLD + 1);

    bc_state_e       state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   own_q, own_d;
    logic            vld_q, tmo_q, tmo_d;

    logic            lock_own, keep, forced, found;
    logic [NREQ-1:0] req_m;
    logic [IW-1:0]   win;

    always_comb begin
        lock_own = ps_bc_lock[own_q];
        keep     = (state_q == BC_OWN) && lock_own && (hold_q <  HW'(MAXHOLD));
        forced   = (state_q == BC_OWN) && lock_own && (hold_q == HW'(MAXHOLD));
        // A force-released owner sits out exactly one arbitration.
        req_m    = ps_bc_req;
        if (forced) req_m[own_q] = 1'b0;
    end

    ps_bc_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i    (req_m),
        .rr_ptr_i (rr_q),
        .found_o  (found),
        .winner_o (win)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        own_d   = own_q;
        tmo_d   = forced;
        if (keep) begin
            hold_d = hold_q + HW'(1);
        end else if (found) begin
            state_d    = BC_OWN;
            hold_d     = HW'(1);
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            own_d      = win;
            if (win != '0) rr_d = (win == IW'(NREQ - 1)) ? IW'(1) : win + IW'(1);
        end else begin
            state_d = BC_IDLE;
            hold_d  = '0;
            gnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= BC_IDLE;
            hold_q  <= '0;
            rr_q    <= IW'(1);
            gnt_q   <= '0;
            own_q   <= '0;
            vld_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            vld_q   <= |gnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign ps_bc_gnt = gnt_q;
    assign ps_bc_own = own_q;
    assign ps_bc_vld = vld_q;
    assign ps_bc_tmo = tmo_q;

endmodule

// File: tb/tb_ps_bc_arbiter.sv
// Bench for ps_bc_arbiter: vector table, hand-written corner sequences and a
// randomized run against an ownership/round-robin reference model.
module tb_ps_bc_arbiter;
    localparam int NREQ    = 4;
    localparam int MAXHOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] lock = '0;
    logic [3:0] gnt;
    logic [1:0] own;
    logic       vld, tmo;

    int checks = 0;
    int failures = 0;

    ps_bc_arbiter #(.NREQ(NREQ), .MAXHOLD(MAXHOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps_bc_req  (req),
        .ps_bc_lock (lock),
        .ps_bc_gnt  (gnt),
        .ps_bc_own  (own),
        .ps_bc_vld  (vld),
        .ps_bc_tmo  (tmo)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the bus, for how long, and where the rotation resumes.
    bit m_owned;
    int m_own, m_hold, m_rr;
    bit m_tmo;

    task automatic model_update(input logic r, input logic [3:0] rq, input logic [3:0] lk);
        bit release_now, frc;
        logic [3:0] cand;
        int w, i;
        if (!r) begin
            m_owned = 0; m_own = 0; m_hold = 0; m_rr = 1; m_tmo = 0;
            return;
        end
        release_now = 1; frc = 0;
        if (m_owned && lk[m_own]) begin
            if (m_hold < MAXHOLD) begin m_hold++; release_now = 0; end
            else frc = 1;
        end
        if (release_now) begin
            cand = rq;
            if (frc) cand[m_own] = 1'b0;
            w = -1;
            if (cand[0]) w = 0;
            else
                for (int k = 0; k < NREQ - 1; k++) begin
                    i = 1 + ((m_rr - 1 + k) % (NREQ - 1));
                    if (w < 0 && cand[i]) w = i;
                end
            if (w >= 0) begin
                m_owned = 1; m_own = w; m_hold = 1;
                if (w != 0) m_rr = (w == NREQ - 1) ? 1 : w + 1;
            end else begin
                m_owned = 0; m_hold = 0;
            end
        end
        m_tmo = frc;
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk);
        @(negedge clk);
        rst = r; req = rq; lock = lk;
        @(posedge clk);
        model_update(r, rq, lk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] eg, input logic [1:0] eo,
                           input logic ev, input logic et);
        chk({name, ".gnt"}, int'(gnt), int'(eg));
        chk({name, ".own"}, int'(own), int'(eo));
        chk({name, ".vld"}, int'(vld), int'(ev));
        chk({name, ".tmo"}, int'(tmo), int'(et));
    endtask

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic [3:0] lk;
        logic [3:0] eg;
        logic [1:0] eo;
        logic       ev;
        logic       et;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [3:0] rq, lk, mg;
        logic       r;

        // reset, round-robin, idle, DM locked while the stack port requests
        tbl[0]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 4'b1110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 4'b1110, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 4'b1110, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 4'b1110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 4'b0011, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

        for (int v = 0; v < 13; v++) begin
            step(tbl[v].r, tbl[v].rq, tbl[v].lk);
            chk($sformatf("vec%0d", v), int'({gnt, own, vld, tmo}),
                int'({tbl[v].eg, tbl[v].eo, tbl[v].ev, tbl[v].et}));
        end

        // Watchdog: URG locked continuously, forced off after 8 cycles, back after a gap.
        step(1'b0, 4'b0000, 4'b0000);
        for (int e = 1; e <= 11; e++) begin
            step(1'b1, 4'b0100, 4'b0100);
            chk_out($sformatf("wdog%0d", e),
                    (e == 9) ? 4'b0000 : 4'b0100, 2'd2, e != 9, e == 9);
        end

        // Reset in the middle of a locked HOST grant.
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b1, 4'b1000, 4'b1000);
        chk_out("host_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        step(1'b1, 4'b1000, 4'b1000);
        step(1'b0, 4'b1000, 4'b1000);
        chk_out("host_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        step(1'b1, 4'b1000, 4'b0000);
        chk_out("host_again", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Rotation pointer restarts at 1: advance it to 2, reset, then DM must win over URG.
        step(1'b1, 4'b0010, 4'b0000);
        chk_out("rr_adv", 4'b0010, 2'd1, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b1, 4'b0110, 4'b0000);
        chk_out("rr_restart", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            r  = ($urandom_range(0, 59) != 0);
            rq = 4'($urandom_range(0, 15));
            lk = ($urandom_range(0, 3) != 0) ? 4'b1111 : 4'($urandom_range(0, 15));
            step(r, rq, lk);
            mg = m_owned ? 4'(1 << m_own) : 4'b0000;
            chk_out($sformatf("rnd%0d", c), mg, 2'(m_own), m_owned, m_tmo);
            chk($sformatf("rnd%0d.onehot", c), int'($countones(gnt) <= 1), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
